crossbar_switch_tdm_scheduler: RTL and testbench

Time-division scheduled N×N crossbar switch, the ingress/control end for the rotation-only crossbar datapath.
- Each input port presents packets tagged with a destination port.
- The block cycles the rotation amount through 0..N-1, one step per clock.
- Each input holds its packet in a one-entry buffer until the current rotation maps it onto its destination.
- The packet is then rotated onto the output lanes and registered.
- Every rotation is a permutation, so output contention cannot occur.

---
 rtl/crossbar_switch_tdm_scheduler.sv | 111 +++++++++++
 tb/tb_crossbar_switch_tdm_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_switch_tdm_scheduler.sv
// Ingress/control end of a TDM-scheduled NxN rotation crossbar.
// Define CROSSBAR_TDM_BYPASS_EN to let beats that already match the rotation cut straight through to the outputs.
module crossbar_switch_tdm_scheduler #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           in_valid,
  output logic [N-1:0]           in_ready,
  input  logic [N*W-1:0]         in_data,
  input  logic [N*$clog2(N)-1:0] in_dest,
  output logic [N-1:0]           out_valid,
  output logic [N*W-1:0]         out_data,
  output logic [N*$clog2(N)-1:0] out_src,
  output logic [$clog2(N)-1:0]   shift_o
);
  localparam int SW = $clog2(N);
  localparam logic [SW:0] NX = (SW+1)'(N);

  // Operands are below 2N, so a single conditional subtract brings them into 0..N-1.
  function automatic logic [SW-1:0] mod_n(input logic [SW:0] x);
    return (x >= NX) ? SW'(x - NX) : SW'(x);
  endfunction

  logic [SW-1:0] sh;
  logic [SW:0]   sh_inc;

  logic [N-1:0]  full;
  logic [W-1:0]  bdata [N];
  logic [SW-1:0] bdest [N];

  logic [SW-1:0] tgt [N];
  logic [SW-1:0] src [N];
  logic [N-1:0]  dep;
  logic [N-1:0]  acc;
  logic [N-1:0]  byp;
  logic [N-1:0]  emit;
  logic [W-1:0]  edata [N];

  assign sh_inc  = {1'b0, sh} + (SW+1)'(1);
  assign shift_o = sh;

  always_ff @(posedge clk) begin
    if (rst)                 sh <= '0;
    else if (sh_inc == NX)   sh <= '0;
    else                     sh <= sh_inc[SW-1:0];
  end

  // tgt[i] is where input i lands this cycle; src[j] is the input landing on output j.
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign tgt[i]      = mod_n((SW+1)'(i) + {1'b0, sh});
    assign src[i]      = mod_n((SW+1)'(i) + NX - {1'b0, sh});
    assign dep[i]      = full[i] && (tgt[i] == bdest[i]);
    assign in_ready[i] = !full[i] || dep[i];
    assign acc[i]      = in_valid[i] && in_ready[i];
`ifdef CROSSBAR_TDM_BYPASS_EN
    assign byp[i]      = !full[i] && in_valid[i] && (tgt[i] == in_dest[i*SW +: SW]);
`else
    assign byp[i]      = 1'b0;
`endif
    assign emit[i]     = dep[i] || byp[i];
    assign edata[i]    = dep[i] ? bdata[i] : in_data[i*W +: W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
      for (int i = 0; i < N; i++) begin
        bdata[i] <= '0;
        bdest[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (acc[i] && !byp[i]) begin
          full[i]  <= 1'b1;
          bdata[i] <= in_data[i*W +: W];
          bdest[i] <= in_dest[i*SW +: SW];
        end else if (dep[i]) begin
          full[i]  <= 1'b0;
        end
      end
    end
  end

  // Rotation is a permutation, so each output has exactly one candidate source.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
      out_src   <= '0;
    end else begin
      for (int j = 0; j < N; j++) begin
        out_valid[j] <= emit[src[j]];
        if (emit[src[j]]) begin
          out_data[j*W +: W]  <= edata[src[j]];
          out_src[j*SW +: SW] <= src[j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (in_valid[i]) assert (int'(in_dest[i*SW +: SW]) < N);
      end
    end
  end

endmodule

// File: tb/tb_crossbar_switch_tdm_scheduler.sv
// Scoreboard bench for crossbar_switch_tdm_scheduler at N=4, W=8 with directed packets.
module tb_crossbar_switch_tdm_scheduler;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data = '0;
  logic [N*2-1:0] in_dest = '0;
  logic [N-1:0]   out_valid;
  logic [N*W-1:0] out_data;
  logic [N*2-1:0] out_src;
  logic [1:0]     shift_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tsh   = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int         port;
    logic [7:0] data;
    logic [1:0] src;
    int         due;
  } exp_t;
  exp_t sbq[$];

  crossbar_switch_tdm_scheduler #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_dest  (in_dest),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_src  (out_src),
    .shift_o  (shift_o)
  );

  always #5 clk = ~clk;

  // Independent rotation model used only to pick stimulus cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    tsh <= rst ? 0 : (tsh + 1) % N;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_out(input int port, input logic [7:0] d, input logic [1:0] s, input int due);
    exp_t e;
    e.port = port;
    e.data = d;
    e.src  = s;
    e.due  = due;
    sbq.push_back(e);
  endtask

  task automatic drive(input int i, input logic [7:0] d, input logic [1:0] dst);
    in_valid[i]       = 1'b1;
    in_data[i*W +: W] = d;
    in_dest[i*2 +: 2] = dst;
  endtask

  task automatic idle();
    in_valid = '0;
  endtask

  task automatic wait_sh(input int k);
    int n;
    n = 0;
    while (tsh != k && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (tsh != k) check("wait_sh_timeout", tsh, k);
  endtask

  always @(negedge clk) begin
    int idx;
    if (mon_en) begin
      for (int j = 0; j < N; j++) begin
        if (out_valid[j] === 1'b1) begin
          idx = -1;
          foreach (sbq[k]) if (idx < 0 && sbq[k].port == j && sbq[k].due == cyc) idx = k;
          if (idx < 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: port %0d data %0h src %0d at cycle %0d, expected no packet",
                     j, out_data[j*W +: W], out_src[j*2 +: 2], cyc);
          end else begin
            check("out_data", 32'(out_data[j*W +: W]), 32'(sbq[idx].data));
            check("out_src", 32'(out_src[j*2 +: 2]), 32'(sbq[idx].src));
            sbq.delete(idx);
          end
        end
      end
      for (int k = sbq.size() - 1; k >= 0; k--) begin
        if (sbq[k].due <= cyc) begin
          total++;
          bad++;
          $display("FAIL missed_out: port %0d data %0h got no packet, required by cycle %0d",
                   sbq[k].port, sbq[k].data, sbq[k].due);
          sbq.delete(k);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    repeat (3) @(negedge clk);

    // Reset state and free-running rotation
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 4'hF);
    check("rst_shift", shift_o, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_src", out_src, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("shift_seq", shift_o, k % 4);
      check("no_x", $isunknown({out_valid, out_data, out_src, shift_o, in_ready}), 0);
      @(negedge clk);
    end

    // Single packet 0 -> 2 accepted at sh=0
    wait_sh(0);
    c = cyc;
    drive(0, 8'hA5, 2'd2);
    expect_out(2, 8'hA5, 2'd0, c + 3);
    @(negedge clk);
    idle();
    check("t2_ready_held", in_ready, 4'b1110);
    repeat (2) @(negedge clk);
    check("t2_valid", out_valid, 4'b0100);
    @(negedge clk);
    check("t2_clear", out_valid, 4'b0000);

    // Identity burst accepted at sh=2
    wait_sh(2);
    c = cyc;
    for (int i = 0; i < N; i++) begin
      drive(i, 8'(8'h10 + i), 2'(i));
      expect_out(i, 8'(8'h10 + i), 2'(i), c + 3);
    end
    @(negedge clk);
    idle();
    check("t3_ready_full", in_ready, 4'b0000);
    @(negedge clk);
    check("t3_ready_dep", in_ready, 4'b1111);
    @(negedge clk);
    check("t3_valid", out_valid, 4'b1111);

    // Backpressure on input 1
    wait_sh(1);
    c = cyc;
    drive(1, 8'h66, 2'd1);
    expect_out(1, 8'h66, 2'd1, c + 4);
    @(negedge clk);
    drive(1, 8'h77, 2'd1);
    check("t4_ready_sh2", in_ready[1], 0);
    @(negedge clk);
    check("t4_ready_sh3", in_ready[1], 0);
    @(negedge clk);
    check("t4_ready_sh0", in_ready[1], 1);
    expect_out(1, 8'h77, 2'd1, c + 8);
    @(negedge clk);
    idle();
    repeat (5) @(negedge clk);

    // Reset with three buffers full; beat presented during reset is dropped
    wait_sh(0);
    drive(0, 8'hB0, 2'd3);
    drive(1, 8'hB1, 2'd0);
    drive(2, 8'hB2, 2'd1);
    @(negedge clk);
    idle();
    check("t5_ready_full", in_ready, 4'b1000);
    rst = 1'b1;
    drive(3, 8'hB3, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    check("t5_out_valid", out_valid, 0);
    check("t5_shift", shift_o, 0);
    check("t5_in_ready", in_ready, 4'hF);
    repeat (8) @(negedge clk);

    // Input 3 -> output 0 presented at sh=1
    wait_sh(1);
    c = cyc;
    drive(3, 8'h3C, 2'd0);
`ifdef CROSSBAR_TDM_BYPASS_EN
    expect_out(0, 8'h3C, 2'd3, c + 1);
`else
    expect_out(0, 8'h3C, 2'd3, c + 5);
`endif
    @(negedge clk);
    idle();
    repeat (6) @(negedge clk);

    check("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
